// File: rtl/riscv_dmem_responder.sv
// Data-side memory responder for the single-cycle core: word RAM plus an MMIO
// window holding a free-running timer, its compare, a sticky irq and tohost.
module riscv_dmem_responder #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 64,
    parameter logic [XLEN-1:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] WD,
    input  logic            WE,
    output logic [XLEN-1:0] RD,
    output logic            timer_irq,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_valid,
    output logic            halt
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OFS_TOHOST   = 2'd0;
    localparam logic [1:0] OFS_MTIME    = 2'd1;
    localparam logic [1:0] OFS_MTIMECMP = 2'd2;
    localparam logic [1:0] OFS_STATUS   = 2'd3;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic            irq_q, irq_d;
    logic [XLEN-1:0] tohost_q, tohost_d;
    logic            tohost_valid_q, tohost_valid_d;
    logic            halt_q, halt_d;

    logic            ram_hit, mmio_hit;
    logic [AW-1:0]   ram_idx;
    logic            we_tohost, we_mtime, we_mtimecmp, we_status;
    logic [XLEN-1:0] rd_data;

    always_comb begin
        ram_hit     = (A[XLEN-1:AW+2] == '0);
        ram_idx     = A[AW+1:2];
        // MMIO registers are only reachable with word-aligned addresses
        mmio_hit    = (A[XLEN-1:4] == MMIO_BASE[XLEN-1:4]) && (A[1:0] == 2'b00);
        we_tohost   = WE && mmio_hit && (A[3:2] == OFS_TOHOST);
        we_mtime    = WE && mmio_hit && (A[3:2] == OFS_MTIME);
        we_mtimecmp = WE && mmio_hit && (A[3:2] == OFS_MTIMECMP);
        we_status   = WE && mmio_hit && (A[3:2] == OFS_STATUS);
    end

    always_comb begin
        mtime_d        = we_mtime ? WD : mtime_q + XLEN'(1);
        mtimecmp_d     = we_mtimecmp ? WD : mtimecmp_q;
        irq_d          = irq_q;
        if (we_status && WD[0])
            irq_d = 1'b0;
        // set is applied after clear so a coincident match wins
        if (mtime_q == mtimecmp_q)
            irq_d = 1'b1;
        tohost_d       = we_tohost ? WD : tohost_q;
        tohost_valid_d = we_tohost;
        halt_d         = halt_q | (we_tohost & WD[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q        <= '0;
            mtimecmp_q     <= '1;
            irq_q          <= 1'b0;
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            mtime_q        <= mtime_d;
            mtimecmp_q     <= mtimecmp_d;
            irq_q          <= irq_d;
            tohost_q       <= tohost_d;
            tohost_valid_q <= tohost_valid_d;
            halt_q         <= halt_d;
        end
    end

    // RAM has no reset and keeps accepting stores while reset is asserted
    always_ff @(posedge clk) begin
        if (WE && ram_hit)
            mem_q[ram_idx] <= WD;
    end

    always_comb begin
        rd_data = '0;
        if (ram_hit) begin
            rd_data = mem_q[ram_idx];
        end else if (mmio_hit) begin
            case (A[3:2])
                OFS_TOHOST:   rd_data = tohost_q;
                OFS_MTIME:    rd_data = mtime_q;
                OFS_MTIMECMP: rd_data = mtimecmp_q;
                default:      rd_data = {{(XLEN-1){1'b0}}, irq_q};
            endcase
        end
    end

    assign RD           = rd_data;
    assign timer_irq    = irq_q;
    assign tohost       = tohost_q;
    assign tohost_valid = tohost_valid_q;
    assign halt         = halt_q;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: RAM, timer/compare/irq, tohost/halt,
// decode boundaries and reset behaviour, checked with immediate assertions.
module tb_riscv_dmem_responder;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, WD, RD, tohost;
    logic        WE, timer_irq, tohost_valid, halt;

    int checks = 0;
    int errors = 0;

    riscv_dmem_responder #(.XLEN(32), .DEPTH(64), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .A(A), .WD(WD), .WE(WE), .RD(RD),
        .timer_irq(timer_irq), .tohost(tohost), .tohost_valid(tohost_valid),
        .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // every task starts just after a negedge; cyc advances exactly one posedge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        A = addr; WD = data; WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        A = addr; WE = 1'b0;
        #1;
        chk(tag, RD, exp);
    endtask

    initial begin
        reset = 1'b1; A = '0; WD = '0; WE = 1'b0;
        repeat (2) cyc();
        chk("rst_irq", 32'(timer_irq), 32'd0);
        chk("rst_tohost", tohost, 32'd0);
        chk("rst_valid", 32'(tohost_valid), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        rd("rst_mtime", MB + 4, 32'd0);
        wr(MB + 8, 32'h0000_1234);
        rd("rst_cmp_write_dropped", MB + 8, 32'hFFFF_FFFF);
        rd("rst_status", MB + 12, 32'd0);

        reset = 1'b0;
        repeat (10) cyc();
        rd("mtime_10", MB + 4, 32'd10);

        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_11", 32'h11, 32'hDEAD_BEEF);
        rd("ram_13", 32'h13, 32'hDEAD_BEEF);
        wr(32'hFC, 32'hCAFE_F00D);
        rd("ram_top", 32'hFC, 32'hCAFE_F00D);
        rd("unmapped_100", 32'h100, 32'd0);
        rd("unmapped_mmio10", MB + 32'h10, 32'd0);

        wr(32'h8, 32'h1111_1111);
        A = 32'h8; WD = 32'h2222_2222; WE = 1'b1;
        #1 chk("rdw_old", RD, 32'h1111_1111);
        cyc();
        WE = 1'b0;
        #1 chk("rdw_new", RD, 32'h2222_2222);

        // wrap through 0xFFFFFFFF also matches the reset compare value
        wr(MB + 4, 32'hFFFF_FFFE);
        rd("wrap_fe", MB + 4, 32'hFFFF_FFFE);
        cyc();
        rd("wrap_ff", MB + 4, 32'hFFFF_FFFF);
        cyc();
        rd("wrap_0", MB + 4, 32'd0);
        chk("wrap_irq", 32'(timer_irq), 32'd1);
        wr(MB + 12, 32'd1);
        chk("w1c_after_wrap", 32'(timer_irq), 32'd0);

        wr(MB + 4, 32'd5);
        wr(MB + 8, 32'd20);
        rd("cmp_mtime6", MB + 4, 32'd6);
        repeat (14) cyc();
        rd("cmp_mtime20", MB + 4, 32'd20);
        chk("cmp_irq_not_yet", 32'(timer_irq), 32'd0);
        cyc();
        chk("cmp_irq_set", 32'(timer_irq), 32'd1);
        rd("status_1", MB + 12, 32'd1);
        wr(MB + 12, 32'd0);
        chk("w0_no_effect", 32'(timer_irq), 32'd1);
        wr(MB + 12, 32'd1);
        rd("status_cleared", MB + 12, 32'd0);

        wr(MB + 4, 32'd19);
        cyc();
        chk("setwin_pre", 32'(timer_irq), 32'd0);
        wr(MB + 12, 32'd1);
        chk("set_wins", 32'(timer_irq), 32'd1);
        wr(MB + 12, 32'd1);
        chk("clear_again", 32'(timer_irq), 32'd0);

        wr(MB, 32'h2A);
        chk("tohost_2a", tohost, 32'h2A);
        chk("valid_pulse", 32'(tohost_valid), 32'd1);
        chk("halt_0", 32'(halt), 32'd0);
        rd("tohost_read", MB, 32'h2A);
        cyc();
        chk("valid_drop", 32'(tohost_valid), 32'd0);
        A = MB; WD = 32'h10; WE = 1'b1;
        cyc();
        WD = 32'h20;
        #1 chk("b2b_valid1", 32'(tohost_valid), 32'd1);
        chk("b2b_tohost1", tohost, 32'h10);
        cyc();
        WE = 1'b0;
        #1 chk("b2b_valid2", 32'(tohost_valid), 32'd1);
        chk("b2b_tohost2", tohost, 32'h20);
        cyc();
        chk("b2b_drop", 32'(tohost_valid), 32'd0);
        wr(MB, 32'd1);
        chk("halt_set", 32'(halt), 32'd1);
        wr(MB, 32'h40);
        chk("halt_held", 32'(halt), 32'd1);
        chk("tohost_40", tohost, 32'h40);

        A = MB + 5; WD = 32'hFFFF_FFFF; WE = 1'b1;
        #1 chk("mis_rd", RD, 32'd0);
        cyc();
        WE = 1'b0;
        rd("mis_cmp", MB + 8, 32'd20);
        rd("mis_status", MB + 12, 32'd0);
        A = MB + 4;
        #1 chk("mis_mtime", 32'(RD < 32'd100), 32'd1);
        chk("mis_tohost", tohost, 32'h40);

        reset = 1'b1;
        wr(MB + 8, 32'h55);
        wr(32'h20, 32'h0000_ABCD);
        chk("rst2_halt", 32'(halt), 32'd0);
        chk("rst2_tohost", tohost, 32'd0);
        chk("rst2_valid", 32'(tohost_valid), 32'd0);
        rd("rst2_cmp", MB + 8, 32'hFFFF_FFFF);
        rd("rst2_mtime", MB + 4, 32'd0);
        reset = 1'b0;
        rd("rst2_ram_write", 32'h20, 32'h0000_ABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
- Memory-side responder for the single-cycle core's data port.
- The core drives the address (its ALUResult), the write data and the write strobe. This block answers with read data in the same cycle.
- Contains word-addressed data RAM plus a small MMIO window: free-running timer, compare register, sticky timer-interrupt status and a test "tohost" register that ends simulation runs.
- Sits in the top level beside instruction memory, between the core and the bench.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 64, RAM size in 32-bit words; power of two, ≥ 4.
- MMIO_BASE, 32'h8000_0000, base of MMIO window; 16-byte aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  XLEN  byte address from core.
- WD  input  XLEN  store data from core.
- WE  input  1  store strobe (core MemWrite).
- RD  output  XLEN  load data to core, combinational.
- timer_irq  output  1  sticky timer-interrupt flag.
- tohost  output  XLEN  last value written to TOHOST.
- tohost_valid  output  1  one-cycle pulse per TOHOST write.
- halt  output  1  sticky end-of-test flag.

Behaviour:
- Decode:
  - RAM when A < DEPTH*4; word index A[log2(DEPTH)+1:2]; A[1:0] ignored.
  - MMIO_BASE+0 TOHOST, +4 MTIME, +8 MTIMECMP, +C STATUS. MMIO requires A[1:0]==0; otherwise unmapped.
  - All else unmapped: reads return 0, writes ignored.
- Read path:
  - RD is purely combinational from A and current register/RAM state, with zero latency. This is required by the single-cycle core.
  - Read-during-write to the same location returns the old value that cycle and the new value from the next cycle.
- RAM:
  - Written at posedge clk when WE and RAM decode hit; full word only.
  - Contents are not cleared by reset; undefined until written. Bench preloads via hierarchical init or writes.
- MTIME:
  - Resets to 0; increments by 1 every cycle when reset is low.
  - Wraps 0xFFFF_FFFF → 0.
  - A write loads WD and takes precedence over the increment; the next cycle continues from WD+1.
- MTIMECMP:
  - Resets to 0xFFFF_FFFF; loaded from WD on write.
- Timer status:
  - The stored bit sets on the cycle after a cycle in which MTIME == MTIMECMP (compare on register values).
  - timer_irq = stored bit. Reset value 0.
  - STATUS read returns {XLEN-1 zeros, timer_irq}.
  - STATUS write with WD[0]=1 clears the bit (W1C); WD[0]=0 has no effect.
  - Set and clear in the same cycle: set wins.
- TOHOST:
  - Reset: tohost=0, tohost_valid=0, halt=0.
  - A write latches WD into tohost and pulses tohost_valid high for exactly the following cycle.
  - Back-to-back writes keep tohost_valid high for consecutive cycles.
  - If WD[0]=1, halt sets and stays set until reset. Further writes still update tohost.
  - TOHOST read returns tohost.
- WE is sampled only at posedge. A[1:0] and WD need no stable window beyond setup.
- Reset mid-operation: all MMIO state returns to reset values in the same cycle. A write coinciding with reset is discarded for MMIO registers; RAM still accepts it.
- No X on RD for mapped MMIO or unmapped addresses after reset.
- Implementation size: ~150-250 lines.

Test Plan:
- Write RAM[0x10]=0xDEADBEEF, then read 0x10, 0x11 and 0x13 → RD=0xDEADBEEF each; read 0x14 before any write → not compared. Read 0x100 (DEPTH=64, unmapped) → RD=0.
- Same-address read-during-write: RAM[0x8]=0x1111_1111, then a cycle with A=0x8, WE=1, WD=0x2222_2222 → RD=0x1111_1111 that cycle, 0x2222_2222 next cycle.
- Release reset, read MTIME after 10 cycles → 10. Write MTIME=0xFFFF_FFFE, read over the next cycles → 0xFFFF_FFFF then 0 (wrap).
- Write MTIMECMP=20 at MTIME=5 → timer_irq rises the cycle after MTIME==20. STATUS write 1 → clears. Write MTIME=MTIMECMP-1 with a clear landing on a set cycle → irq remains 1.
- Write TOHOST=0x2A → tohost=0x2A, tohost_valid one-cycle pulse, halt=0. Write TOHOST=1 → halt=1 and held. Assert reset → halt=0, tohost=0.
- Misaligned MMIO write to MMIO_BASE+5 with WE=1 → no register changes, RD=0. Reset asserted with WE=1 to MTIMECMP → MTIMECMP=0xFFFF_FFFF after reset.
